uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares one `uart_transmitter` among NUM_REQ byte producers with round-robin arbitration. It accepts one byte at a time over a valid/ready handshake and issues the transmitter's one-cycle start pulse. It holds the byte stable for the whole frame. The transmitter has no busy output, so the block times frame completion itself with a cycle counter, and never issues a start while a frame can still be in flight.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- CYCLES_PER_SAMPLE, 10416: clock cycles per UART bit; must equal the transmitter's value.
- GUARD_CYCLES, 2: idle cycles inserted after each frame, 0 allowed.
- FRAME_CYCLES, 10*CYCLES_PER_SAMPLE+2 (derived, localparam): cycles from start pulse to transmitter back in IDLE. Covers 1 start + 8 data + 1 stop bit, plus 2 cycles of transmitter input-register latency.
- clk  in  1  system clock.
- r_reset  in  1  reset, synchronous, active-high; clock clk.
- i_req_valid  in  NUM_REQ  per-requester byte available; held until accepted.
- i_req_data  in  NUM_REQ*8  byte of requester k at [8k+7:8k]; stable while valid.
- o_req_ready  out  NUM_REQ  one-hot accept; transfer occurs when valid&ready.
- o_tx_data  out  8  byte to `uart_transmitter.i_data`.
- o_tx_start  out  1  start pulse to `uart_transmitter.i_start_transmission`.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  $clog2(NUM_REQ)  index of requester owning the current or most recent frame.

## Operation
- States are DRAIN, IDLE, LAUNCH, FRAME and GUARD. One counter, width $clog2(FRAME_CYCLES+1), is shared by DRAIN, FRAME and GUARD.
- **Reset:**
  - State goes to DRAIN; counter, o_tx_data and o_grant_id go to 0.
  - The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority.
- **DRAIN:** counts FRAME_CYCLES cycles, then goes to IDLE. This lets a frame that was in flight at reset finish.
- **IDLE:**
  - If no valid is asserted, stay.
  - Otherwise pick the winner w: the first valid requester searching from pointer+1 upward, modulo NUM_REQ.
  - Assert o_req_ready[w] combinationally in this same cycle.
  - On the clock edge: o_tx_data <= byte w, o_grant_id <= w, pointer <= w, state goes to LAUNCH.
- **LAUNCH:** o_tx_start=1 for exactly this cycle. Counter goes to 0; state goes to FRAME.
- **FRAME:**
  - Counter increments each cycle.
  - At FRAME_CYCLES-1, go to GUARD with counter 0, or to IDLE if GUARD_CYCLES=0.
- **GUARD:** lasts GUARD_CYCLES cycles, then goes to IDLE.
- Requests presented outside IDLE are ignored (ready=0); they are not queued.
- o_tx_data changes only on acceptance, and is held through LAUNCH, FRAME and GUARD.
- The byte is passed through unmodified; bit order on the line is the transmitter's concern.

## Timing
- Reset values: o_req_ready=0, o_tx_start=0, o_busy=1 (DRAIN), o_tx_data=0, o_grant_id=0.
- First possible accept is FRAME_CYCLES cycles after the reset edge.
- Acceptance in cycle t gives o_tx_start=1 in cycle t+1, and o_busy=1 from t+1.
- Earliest next accept is at t+2+FRAME_CYCLES+GUARD_CYCLES.
- Under continuous load, accepts are spaced FRAME_CYCLES+GUARD_CYCLES+2 cycles apart.
- o_req_ready is at most one-hot; all other outputs are decoded from registers only.
- Reset mid-frame: the next cycle is DRAIN and o_tx_start is forced to 0; the pending captured byte is dropped.
- Reset asserted in the same cycle as an acceptance: reset wins. Ready may still be high that cycle (the combinational ready comes from the registered IDLE state), but nothing is captured into o_tx_data/o_grant_id and no start pulse is issued. The requester must treat the byte as lost.
- Only one requester is valid: it wins regardless of pointer.

## Structure
- Shared package `uart_pkg`:
  - `TxSchedState` enum (DRAIN, IDLE, LAUNCH, FRAME, GUARD);
  - FRAME_BITS=10;
  - TX_LAUNCH_LATENCY=2.
- FRAME_CYCLES is derived from these constants.
- One sub-module, `rr_arbiter`: a combinational round-robin picker with parameter N.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and grant index.

## Test plan
Bench parameters: CYCLES_PER_SAMPLE=4, GUARD_CYCLES=2, so FRAME_CYCLES=42. Each scenario also checks the byte serialised by a real `uart_transmitter`.
- **Reset drain:** reset, with i_req_valid=4'b0001 held from the cycle after the reset edge. → o_req_ready stays 0 for 42 cycles and o_busy=1; accept occurs on cycle 42; o_tx_start on cycle 43.
- **Single byte:** requester 2 sends 0xA5. → one ready pulse, o_grant_id=2, o_tx_data=0xA5 held for 45 cycles, o_tx_start high exactly one cycle, the line carries frame 0xA5.
- **Fairness:** all four requesters continuously valid with bytes 0x10..0x13. → grant order 0,1,2,3,0; accepts exactly 46 cycles apart.
- **Skip idle requesters:** only requesters 1 and 3 are valid. → grants alternate 1,3,1; requesters 0 and 2 never see ready.
- **Reset mid-frame:** assert reset 20 cycles into FRAME. → no o_tx_start for the next 42 cycles; the transmitter returns to IDLE before the next start pulse.
- **GUARD_CYCLES=0:** back-to-back load. → accepts spaced 44 cycles apart, with no overlapping frames on the line.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    DRAIN  = 3'd0,
    IDLE   = 3'd1,
    LAUNCH = 3'd2,
    FRAME  = 3'd3,
    GUARD  = 3'd4
  } TxSchedState;

  localparam int FRAME_BITS        = 10;
  localparam int TX_LAUNCH_LATENCY = 2;

  // Cycles from the transmitter start pulse until it is back in IDLE.
  function automatic int frame_cycles(input int cycles_per_sample);
    return FRAME_BITS * cycles_per_sample + TX_LAUNCH_LATENCY;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  int   cand_s;
  logic found_s;

  // Scan ptr+1 .. ptr+N and keep the first asserted request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int off = 1; off <= N; off++) begin
      cand_s = (int'(ptr) + off) % N;
      if (!found_s && req[IDX_W'(cand_s)]) begin
        grant[IDX_W'(cand_s)] = 1'b1;
        grant_idx             = IDX_W'(cand_s);
        found_s               = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_transmitter among NUM_REQ byte producers;
// frame completion is timed locally since the transmitter has no busy output.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int CYCLES_PER_SAMPLE = 10416,
  parameter int GUARD_CYCLES      = 2
) (
  input  logic                       clk,
  input  logic                       r_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int FRAME_CYCLES = frame_cycles(CYCLES_PER_SAMPLE);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam int IDX_W        = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam logic [IDX_W-1:0] PTR_INIT   = IDX_W'(NUM_REQ - 1);

  TxSchedState        state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [7:0]         tx_data_r, tx_data_s;
  logic [IDX_W-1:0]   grant_id_r, grant_id_s;
  logic [IDX_W-1:0]   ptr_r, ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   win_idx_s;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req       (i_req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (win_idx_s)
  );

  // State, frame counter and captured-byte registers.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_r    <= DRAIN;
      cnt_r      <= '0;
      tx_data_r  <= 8'h00;
      grant_id_r <= '0;
      ptr_r      <= PTR_INIT;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      tx_data_r  <= tx_data_s;
      grant_id_r <= grant_id_s;
      ptr_r      <= ptr_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tx_data_s  = tx_data_r;
    grant_id_s = grant_id_r;
    ptr_s      = ptr_r;
    case (state_r)
      DRAIN: begin
        // Give a frame that was in flight across reset time to finish.
        if (cnt_r == FRAME_LAST) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      IDLE: begin
        if (|i_req_valid) begin
          state_s    = LAUNCH;
          tx_data_s  = i_req_data[{win_idx_s, 3'b000} +: 8];
          grant_id_s = win_idx_s;
          ptr_s      = win_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        state_s = FRAME;
        cnt_s   = '0;
      end
      FRAME: begin
        if (cnt_r == FRAME_LAST) begin
          state_s = (GUARD_CYCLES == 0) ? IDLE : GUARD;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = DRAIN;
        cnt_s   = '0;
      end
    endcase
  end

  // Ready is offered only from the registered IDLE state.
  always_comb begin
    o_req_ready = '0;
    if (state_r == IDLE) begin
      o_req_ready = grant_s;
    end else begin
      o_req_ready = '0;
    end
  end

  assign o_tx_start = (state_r == LAUNCH);
  assign o_busy     = (state_r != IDLE);
  assign o_tx_data  = tx_data_r;
  assign o_grant_id = grant_id_r;

endmodule
